// File: rtl/tcrc_pkg.sv
// Shared definitions for the transmit-CRC sequencer: CRC geometry, state encoding, counter helper.
package tcrc_pkg;

    localparam int unsigned CRC_LEN = 15;
    localparam int unsigned CNT_W   = 4;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counter value at which flush / shift-out is complete.
    localparam cnt_t CNT_LAST = cnt_t'(CRC_LEN);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_PRELOAD  = 3'd1;
    localparam logic [2:0] S_CALC     = 3'd2;
    localparam logic [2:0] S_FLUSH    = 3'd3;
    localparam logic [2:0] S_WAIT_CRC = 3'd4;
    localparam logic [2:0] S_SHIFT    = 3'd5;
    localparam logic [2:0] S_DONE     = 3'd6;

    typedef enum logic [2:0] {
        StIdle    = S_IDLE,
        StPreload = S_PRELOAD,
        StCalc    = S_CALC,
        StFlush   = S_FLUSH,
        StWaitCrc = S_WAIT_CRC,
        StShift   = S_SHIFT,
        StDone    = S_DONE
    } seq_state_e;

    // Saturating increment: the counter stops at CRC_LEN and never wraps.
    function automatic cnt_t cnt_inc(input cnt_t c);
        cnt_t r;
        r = (c == CNT_LAST) ? c : c + cnt_t'(1);
        return r;
    endfunction

endpackage

// File: rtl/tcrc_strobe_gen.sv
// Turns a request into a registered 1-high/1-low strobe for tcrc2, which edge-detects on negedge.
module tcrc_strobe_gen (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic req_i,
    output logic strobe_o,
    output logic ready_o
);

    logic strobe_q, strobe_d;

    // A request while the strobe is high is dropped so there is always a low clock between pulses.
    always_comb begin
        strobe_d = 1'b0;
        if (!clr_i && req_i && !strobe_q) begin
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe_o = strobe_q;
    assign ready_o  = !strobe_q;

endmodule

// File: rtl/tcrc_seq.sv
// Sequencer for the tcrc2 transmit-CRC register: preload, data steps, zero flush, serial shift-out.
// Optional sticky sequencing checker enabled by defining TCRC_SEQ_ERRCHK_EN.
module tcrc_seq
    import tcrc_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic frame_start_i,
    input  logic extended_i,
    input  logic bit_tick_i,
    input  logic stuff_bit_i,
    input  logic data_end_i,
    input  logic crc_field_start_i,
    input  logic abort_i,
    output logic activ_o,
    output logic load_o,
    output logic load_activ_o,
    output logic crc_shft_out_o,
    output logic zerointcrc_o,
    output logic extended_o,
    output logic crc_busy_o,
    output logic crc_done_o,
    output logic crc_seq_err_o
);

    seq_state_e state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic       ext_q, ext_d;
    logic       load_q, load_d;
    logic       zero_q, zero_d;
    logic       shft_q, shft_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic tick_ok;
    logic act_req, act_rdy, act_strobe;
    logic la_req, la_rdy, la_strobe;

    assign tick_ok = bit_tick_i && !stuff_bit_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ext_d   = ext_q;
        load_d  = 1'b0;
        act_req = 1'b0;
        la_req  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (frame_start_i) begin
                    state_d = StPreload;
                    ext_d   = extended_i;
                end
            end
            StPreload: begin
                load_d  = 1'b1;
                la_req  = 1'b1;
                state_d = StCalc;
            end
            StCalc: begin
                // A step coinciding with data_end is still issued before the flush starts.
                act_req = tick_ok;
                if (data_end_i) begin
                    state_d = StFlush;
                    cnt_d   = '0;
                end
            end
            StFlush: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StWaitCrc;
                end else if (act_rdy) begin
                    act_req = 1'b1;
                    cnt_d   = cnt_inc(cnt_q);
                end
            end
            StWaitCrc: begin
                if (crc_field_start_i) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                end else if (tick_ok && la_rdy) begin
                    la_req = 1'b1;
                    cnt_d  = cnt_inc(cnt_q);
                end
            end
            StDone: begin
                if (frame_start_i) begin
                    state_d = StPreload;
                    ext_d   = extended_i;
                end else begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort_i) begin
            state_d = StIdle;
            cnt_d   = '0;
            load_d  = 1'b0;
            act_req = 1'b0;
            la_req  = 1'b0;
        end
    end

    // Zero injection only covers clocks that stay inside FLUSH, so a data step issued on the
    // entry edge still sees the real data bit.
    always_comb begin
        zero_d = !((state_q == StFlush) && (state_d == StFlush));
        shft_d = (state_d == StShift);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            ext_q   <= 1'b0;
            load_q  <= 1'b0;
            zero_q  <= 1'b1;
            shft_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ext_q   <= ext_d;
            load_q  <= load_d;
            zero_q  <= zero_d;
            shft_q  <= shft_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    tcrc_strobe_gen u_activ_strobe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (abort_i),
        .req_i    (act_req),
        .strobe_o (act_strobe),
        .ready_o  (act_rdy)
    );

    tcrc_strobe_gen u_load_activ_strobe (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .clr_i    (abort_i),
        .req_i    (la_req),
        .strobe_o (la_strobe),
        .ready_o  (la_rdy)
    );

`ifdef TCRC_SEQ_ERRCHK_EN
    logic err_q, err_d;
    logic err_event;

    assign err_event = (data_end_i && (state_q != StCalc))
                    || (crc_field_start_i && (state_q != StWaitCrc))
                    || (bit_tick_i && (state_q == StFlush));

    // A violation in the same clock as frame_start keeps the flag set.
    always_comb begin
        err_d = err_q;
        if (err_event) begin
            err_d = 1'b1;
        end else if (frame_start_i) begin
            err_d = 1'b0;
        end
        if (abort_i) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign crc_seq_err_o = err_q;
`else
    assign crc_seq_err_o = 1'b0;
`endif

    assign activ_o        = act_strobe;
    assign load_o         = load_q;
    assign load_activ_o   = la_strobe;
    assign crc_shft_out_o = shft_q;
    assign zerointcrc_o   = zero_q;
    assign extended_o     = ext_q;
    assign crc_busy_o     = busy_q;
    assign crc_done_o     = done_q;

endmodule

// File: tb/tb_tcrc_seq.sv
// Directed bench for tcrc_seq with a tcrc2 shift-register model; covers TCRC_SEQ_ERRCHK_EN when set.
module tb_tcrc_seq;

    localparam int GAP = 34;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic frame_start = 1'b0, extended_in = 1'b0, bit_tick = 1'b0, stuff_bit = 1'b0;
    logic data_end = 1'b0, crc_field_start = 1'b0, abort = 1'b0;
    logic activ, load, load_activ, crc_shft_out, zerointcrc, extended, crc_busy, crc_done;
    logic crc_seq_err;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    tcrc_seq dut (
        .clk_i             (clk),
        .rst_ni            (rst_ni),
        .frame_start_i     (frame_start),
        .extended_i        (extended_in),
        .bit_tick_i        (bit_tick),
        .stuff_bit_i       (stuff_bit),
        .data_end_i        (data_end),
        .crc_field_start_i (crc_field_start),
        .abort_i           (abort),
        .activ_o           (activ),
        .load_o            (load),
        .load_activ_o      (load_activ),
        .crc_shft_out_o    (crc_shft_out),
        .zerointcrc_o      (zerointcrc),
        .extended_o        (extended),
        .crc_busy_o        (crc_busy),
        .crc_done_o        (crc_done),
        .crc_seq_err_o     (crc_seq_err)
    );

    // tcrc2 model: plain CRC-15 division register, sampled on negedge with edge detection.
    logic        cur_bit = 1'b0;
    logic [14:0] crc_m = '0;
    logic [14:0] sh_m = '0;
    logic        act_prev = 1'b0, la_prev = 1'b0;
    int          act_cnt = 0, zero_cnt = 0, la_cnt = 0, done_cnt = 0;

    function automatic logic [14:0] crc_step(input logic [14:0] c, input logic b);
        logic        msb;
        logic [14:0] r;
        msb = c[14];
        r   = {c[13:0], b};
        if (msb) r = r ^ 15'h4599;
        return r;
    endfunction

    always @(negedge clk) begin
        act_prev <= activ;
        la_prev  <= load_activ;
        if (activ && !act_prev) begin
            act_cnt <= act_cnt + 1;
            crc_m   <= crc_step(crc_m, zerointcrc ? cur_bit : 1'b0);
            if (!zerointcrc) zero_cnt <= zero_cnt + 1;
        end
        if (load && load_activ && !la_prev) begin
            crc_m <= '0;
        end else if (crc_shft_out && load_activ && !la_prev) begin
            sh_m   <= {sh_m[13:0], crc_m[14]};
            crc_m  <= {crc_m[13:0], 1'b0};
            la_cnt <= la_cnt + 1;
        end
        if (crc_done) done_cnt <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_tick(input logic stuff, input logic b);
        @(posedge clk); #1;
        bit_tick = 1'b1; stuff_bit = stuff; cur_bit = b;
        @(posedge clk); #1;
        bit_tick = 1'b0; stuff_bit = 1'b0;
    endtask

    task automatic pulse_frame_start(input logic ext);
        @(posedge clk); #1;
        frame_start = 1'b1; extended_in = ext;
        @(posedge clk); #1;
        frame_start = 1'b0; extended_in = 1'b0;
    endtask

    task automatic pulse_cfs();
        @(posedge clk); #1 crc_field_start = 1'b1;
        @(posedge clk); #1 crc_field_start = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
    endtask

    initial begin
        logic [16:0] data_w;
        int k;
        int base_act, base_zero, base_la, base_done;
        data_w = 17'h00123;
        k = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_activ", 32'(activ), 32'd0);
        check_eq("rst_load", 32'(load), 32'd0);
        check_eq("rst_load_activ", 32'(load_activ), 32'd0);
        check_eq("rst_shft", 32'(crc_shft_out), 32'd0);
        check_eq("rst_zero", 32'(zerointcrc), 32'd1);
        check_eq("rst_ext", 32'(extended), 32'd0);
        check_eq("rst_busy", 32'(crc_busy), 32'd0);
        check_eq("rst_done", 32'(crc_done), 32'd0);
        check_eq("rst_err", 32'(crc_seq_err), 32'd0);

        // Frame 1: full sequence, extended frame
        pulse_frame_start(1'b1);
        check_eq("f1_ext", 32'(extended), 32'd1);
        check_eq("f1_busy", 32'(crc_busy), 32'd1);
        check_eq("f1_load_early", 32'(load), 32'd0);
        @(posedge clk); #1;
        check_eq("f1_load", 32'(load), 32'd1);
        check_eq("f1_load_activ", 32'(load_activ), 32'd1);
        check_eq("f1_activ_in_preload", 32'(activ), 32'd0);
        @(posedge clk); #1;
        check_eq("f1_load_fall", 32'(load), 32'd0);
        check_eq("f1_load_activ_fall", 32'(load_activ), 32'd0);

        base_act = act_cnt;
        for (int i = 1; i <= 19; i++) begin
            if (i == 5 || i == 11) begin
                pulse_tick(1'b1, 1'b0);
            end else begin
                pulse_tick(1'b0, data_w[16-k]);
                k++;
            end
            repeat (GAP) @(posedge clk);
        end
        #1;
        check_eq("f1_data_steps", 32'(act_cnt - base_act), 32'd17);

        @(posedge clk); #1 data_end = 1'b1;
        @(posedge clk); #1 data_end = 1'b0;
        base_act  = act_cnt;
        base_zero = zero_cnt;
        repeat (30) @(posedge clk);
        #1;
        check_eq("f1_flush_steps", 32'(act_cnt - base_act), 32'd15);
        check_eq("f1_flush_zero", 32'(zero_cnt - base_zero), 32'd15);
        check_eq("f1_zero_back", 32'(zerointcrc), 32'd1);
        check_eq("f1_crc_golden", 32'(crc_m), 32'h143A);

        pulse_cfs();
        check_eq("f1_shft_on", 32'(crc_shft_out), 32'd1);
        base_la   = la_cnt;
        base_done = done_cnt;
        pulse_tick(1'b1, 1'b0);
        repeat (GAP) @(posedge clk);
        for (int i = 1; i <= 14; i++) begin
            pulse_tick(1'b0, 1'b0);
            repeat (GAP) @(posedge clk);
        end
        pulse_tick(1'b0, 1'b0);
        check_eq("f1_last_la", 32'(load_activ), 32'd1);
        check_eq("f1_done_early", 32'(crc_done), 32'd0);
        @(posedge clk); #1;
        check_eq("f1_done", 32'(crc_done), 32'd1);
        check_eq("f1_shft_off", 32'(crc_shft_out), 32'd0);
        @(posedge clk); #1;
        check_eq("f1_done_fall", 32'(crc_done), 32'd0);
        check_eq("f1_idle", 32'(crc_busy), 32'd0);
        check_eq("f1_shift_count", 32'(la_cnt - base_la), 32'd15);
        check_eq("f1_shift_word", 32'(sh_m), 32'h143A);
        check_eq("f1_done_count", 32'(done_cnt - base_done), 32'd1);

        // Frame 2: ignored frame_start, data_end coinciding with a step, abort on 7th shift tick
        pulse_frame_start(1'b1);
        repeat (3) @(posedge clk);
        pulse_frame_start(1'b0);
        check_eq("f2_fs_ignored_load", 32'(load), 32'd0);
        check_eq("f2_ext_kept", 32'(extended), 32'd1);
        @(posedge clk); #1;
        check_eq("f2_fs_ignored_load2", 32'(load), 32'd0);

        base_act  = act_cnt;
        base_zero = zero_cnt;
        pulse_tick(1'b0, 1'b1);
        repeat (GAP) @(posedge clk);
        @(posedge clk); #1;
        bit_tick = 1'b1; data_end = 1'b1; cur_bit = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0; data_end = 1'b0;
        check_eq("f2_coincident_step", 32'(activ), 32'd1);
        repeat (31) @(posedge clk);
        #1;
        check_eq("f2_total_steps", 32'(act_cnt - base_act), 32'd17);
        check_eq("f2_flush_zero", 32'(zero_cnt - base_zero), 32'd15);
        check_eq("f2_zero_back", 32'(zerointcrc), 32'd1);

        pulse_cfs();
        base_la   = la_cnt;
        base_done = done_cnt;
        for (int i = 1; i <= 6; i++) begin
            pulse_tick(1'b0, 1'b0);
            repeat (GAP) @(posedge clk);
        end
        @(posedge clk); #1;
        bit_tick = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        bit_tick = 1'b0; abort = 1'b0;
        check_eq("ab_activ", 32'(activ), 32'd0);
        check_eq("ab_load", 32'(load), 32'd0);
        check_eq("ab_load_activ", 32'(load_activ), 32'd0);
        check_eq("ab_shft", 32'(crc_shft_out), 32'd0);
        check_eq("ab_zero", 32'(zerointcrc), 32'd1);
        check_eq("ab_busy", 32'(crc_busy), 32'd0);
        check_eq("ab_done", 32'(crc_done), 32'd0);
        check_eq("ab_err", 32'(crc_seq_err), 32'd0);
        check_eq("ab_ext_held", 32'(extended), 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check_eq("ab_shift_count", 32'(la_cnt - base_la), 32'd6);
        check_eq("ab_no_done", 32'(done_cnt - base_done), 32'd0);

        // Frame 3: base frame, sequencing-error checks
        pulse_frame_start(1'b0);
        check_eq("f3_ext", 32'(extended), 32'd0);
        repeat (3) @(posedge clk);
`ifdef TCRC_SEQ_ERRCHK_EN
        pulse_cfs();
        check_eq("err_set", 32'(crc_seq_err), 32'd1);
        check_eq("err_no_shift", 32'(crc_shft_out), 32'd0);
`endif
        pulse_tick(1'b0, 1'b0);
        check_eq("f3_still_calc", 32'(activ), 32'd1);
        repeat (GAP) @(posedge clk);
`ifdef TCRC_SEQ_ERRCHK_EN
        check_eq("err_sticky", 32'(crc_seq_err), 32'd1);
        pulse_frame_start(1'b0);
        check_eq("err_cleared", 32'(crc_seq_err), 32'd0);
        check_eq("err_fs_ignored", 32'(load), 32'd0);
`endif
        pulse_abort();
        check_eq("f3_abort_idle", 32'(crc_busy), 32'd0);

        repeat (5) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
